// File: rtl/idex_stage_if.sv
// Bundle of decode-side inputs, forwarding sources, pipeline control and
// EXE-side outputs around the decode-to-execute register.
interface idex_stage_if;
  logic        dec_valid_r;
  logic [31:0] dec_instr_r;
  logic [31:0] dec_pc_r;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        mem_wb_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        stall;
  logic        flush;

  logic        exe_valid_r;
  logic [3:0]  exe_alu_opc_r;
  logic        exe_sel_pc_r;
  logic [31:0] exe_pc_r;
  logic [31:0] exe_reg1_r;
  logic [31:0] exe_src2_r;
  logic [4:0]  exe_rd_r;
  logic        exe_wb_en_r;
  logic        exe_illegal_r;

  modport master (
    output dec_valid_r, dec_instr_r, dec_pc_r, rf_rdata1, rf_rdata2,
           mem_wb_en, mem_rd, mem_result, wb_wb_en, wb_rd, wb_result,
           stall, flush,
    input  exe_valid_r, exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r,
           exe_src2_r, exe_rd_r, exe_wb_en_r, exe_illegal_r
  );

  modport slave (
    input  dec_valid_r, dec_instr_r, dec_pc_r, rf_rdata1, rf_rdata2,
           mem_wb_en, mem_rd, mem_result, wb_wb_en, wb_rd, wb_result,
           stall, flush,
    output exe_valid_r, exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r,
           exe_src2_r, exe_rd_r, exe_wb_en_r, exe_illegal_r
  );
endinterface

// File: rtl/idex_stage.sv
// RV32I decode-to-execute register: decodes OP/OP-IMM/LUI/AUIPC into ALU
// controls, forwards operands from MEM/WB and registers them for the ALU.
module idex_stage (
  input  logic         clk,
  input  logic         rst,
  idex_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = bus.dec_instr_r[6:0];
  assign funct3 = bus.dec_instr_r[14:12];
  assign funct7 = bus.dec_instr_r[31:25];
  assign rd     = bus.dec_instr_r[11:7];

  // Decode
  logic        supported;
  logic [3:0]  dec_opc;
  logic        dec_sel_pc;
  logic        dec_use_imm;
  logic        dec_zero_rs1;
  logic [31:0] dec_imm;

  always_comb begin
    supported    = 1'b0;
    dec_opc      = ALU_ADD;
    dec_sel_pc   = 1'b0;
    dec_use_imm  = 1'b0;
    dec_zero_rs1 = 1'b0;
    dec_imm      = 32'd0;
    case (opcode)
      OPC_OP: begin
        dec_opc   = {bus.dec_instr_r[30], funct3};
        supported = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec_use_imm = 1'b1;
        dec_imm     = {{20{bus.dec_instr_r[31]}}, bus.dec_instr_r[31:20]};
        dec_opc     = {(funct3 == 3'b101) ? bus.dec_instr_r[30] : 1'b0, funct3};
        case (funct3)
          3'b001:  supported = (funct7 == F7_ZERO);
          3'b101:  supported = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          default: supported = 1'b1;
        endcase
      end
      OPC_LUI: begin
        supported    = 1'b1;
        dec_use_imm  = 1'b1;
        dec_zero_rs1 = 1'b1;
        dec_imm      = {bus.dec_instr_r[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        supported   = 1'b1;
        dec_use_imm = 1'b1;
        dec_sel_pc  = 1'b1;
        dec_imm     = {bus.dec_instr_r[31:12], 12'd0};
      end
      default: supported = 1'b0;
    endcase
  end

  // Operand forwarding; MEM is the younger producer so it takes priority over WB
  logic [1:0][4:0]  rs_idx;
  logic [1:0][31:0] rf_data;
  logic [1:0][31:0] fwd_data;

  assign rs_idx[0]  = bus.dec_instr_r[19:15];
  assign rs_idx[1]  = bus.dec_instr_r[24:20];
  assign rf_data[0] = bus.rf_rdata1;
  assign rf_data[1] = bus.rf_rdata2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_data[gi] = rf_data[gi];
        if (rs_idx[gi] == 5'd0)
          fwd_data[gi] = 32'd0;
        else if (bus.mem_wb_en && (bus.mem_rd == rs_idx[gi]))
          fwd_data[gi] = bus.mem_result;
        else if (bus.wb_wb_en && (bus.wb_rd == rs_idx[gi]))
          fwd_data[gi] = bus.wb_result;
      end
    end
  endgenerate

  // Value to load when neither reset, flush nor stall applies
  logic        load_ok;
  logic        valid_next;
  logic [3:0]  opc_next;
  logic        sel_pc_next;
  logic [31:0] pc_next;
  logic [31:0] reg1_next;
  logic [31:0] src2_next;
  logic [4:0]  rd_next;
  logic        wb_en_next;
  logic        illegal_next;

  assign load_ok = bus.dec_valid_r && supported;

  always_comb begin
    valid_next   = 1'b0;
    opc_next     = ALU_ADD;
    sel_pc_next  = 1'b0;
    pc_next      = 32'd0;
    reg1_next    = 32'd0;
    src2_next    = 32'd0;
    rd_next      = 5'd0;
    wb_en_next   = 1'b0;
    illegal_next = bus.dec_valid_r && !supported;
    if (load_ok) begin
      valid_next  = 1'b1;
      opc_next    = dec_opc;
      sel_pc_next = dec_sel_pc;
      pc_next     = bus.dec_pc_r;
      reg1_next   = dec_zero_rs1 ? 32'd0 : fwd_data[0];
      src2_next   = dec_use_imm ? dec_imm : fwd_data[1];
      rd_next     = rd;
      wb_en_next  = (rd != 5'd0);
    end
  end

  logic        valid_reg;
  logic [3:0]  opc_reg;
  logic        sel_pc_reg;
  logic [31:0] pc_reg;
  logic [31:0] reg1_reg;
  logic [31:0] src2_reg;
  logic [4:0]  rd_reg;
  logic        wb_en_reg;
  logic        illegal_reg;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_reg   <= 1'b0;
      opc_reg     <= ALU_ADD;
      sel_pc_reg  <= 1'b0;
      pc_reg      <= 32'd0;
      reg1_reg    <= 32'd0;
      src2_reg    <= 32'd0;
      rd_reg      <= 5'd0;
      wb_en_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg   <= valid_next;
      opc_reg     <= opc_next;
      sel_pc_reg  <= sel_pc_next;
      pc_reg      <= pc_next;
      reg1_reg    <= reg1_next;
      src2_reg    <= src2_next;
      rd_reg      <= rd_next;
      wb_en_reg   <= wb_en_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.exe_valid_r   = valid_reg;
  assign bus.exe_alu_opc_r = opc_reg;
  assign bus.exe_sel_pc_r  = sel_pc_reg;
  assign bus.exe_pc_r      = pc_reg;
  assign bus.exe_reg1_r    = reg1_reg;
  assign bus.exe_src2_r    = src2_reg;
  assign bus.exe_rd_r      = rd_reg;
  assign bus.exe_wb_en_r   = wb_en_reg;
  assign bus.exe_illegal_r = illegal_reg;

endmodule

// File: doc/idex_stage.md
# idex_stage

Decode-to-execute pipeline register for the RV32I core. It decodes the instruction held at the decode stage into ALU controls (opcode, PC-select, immediate). It also selects forwarded register operands and registers everything into the `exe_*` signals consumed directly by the integer ALU. It supports stall (hold), flush (bubble insertion) and flags unsupported encodings.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `dec_valid_r`  in  1  decode stage holds a valid instruction
- `dec_instr_r`  in  32  instruction word at decode
- `dec_pc_r`  in  32  PC of that instruction
- `rf_rdata1`, `rf_rdata2`  in  32 each  register file read data for rs1 = `instr[19:15]` and rs2 = `instr[24:20]`; no write-through
- `mem_wb_en`, `mem_rd`, `mem_result`  in  1/5/32  writeback intent, destination and result of the instruction now in MEM
- `wb_wb_en`, `wb_rd`, `wb_result`  in  1/5/32  same, for the instruction now in WB
- `stall`  in  1  hold all `exe_*` registers
- `flush`  in  1  replace the next `exe_*` contents with a bubble
- `exe_valid_r`  out  1  EXE holds a valid ALU instruction
- `exe_alu_opc_r`  out  4  ALU opcode
- `exe_sel_pc_r`  out  1  first ALU operand is PC (1) or reg1 (0)
- `exe_pc_r`, `exe_reg1_r`, `exe_src2_r`  out  32 each  ALU operands
- `exe_rd_r`  out  5  destination register
- `exe_wb_en_r`  out  1  result must be written back
- `exe_illegal_r`  out  1  one-cycle flag: valid decode slot held an unsupported encoding

## Operation
- ALU opcode encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- OP (`0110011`):
  - opc = {`instr[30]`, funct3}; src2 = forwarded rs2; sel_pc = 0.
  - Legal only if funct7 = `0000000`, or funct7 = `0100000` with funct3 ∈ {000, 101}.
- OP-IMM (`0010011`):
  - src2 = sign-extended `instr[31:20]`; sel_pc = 0.
  - opc = {funct3==101 ? `instr[30]` : 0, funct3}.
  - funct3 = 001 requires funct7 = 0; funct3 = 101 requires funct7 ∈ {`0000000`, `0100000`}.
- LUI (`0110111`): opc = ADD, sel_pc = 0, reg1 = 0 (forced), src2 = {`instr[31:12]`, 12'b0}.
- AUIPC (`0010111`): opc = ADD, sel_pc = 1, src2 = U-immediate.
- Any other opcode, or an illegal funct field, is unsupported.
- Operand forwarding, per source (rs1, rs2), in priority order:
  - rs = x0 → 0
  - else `mem_wb_en` && `mem_rd` == rs → `mem_result`
  - else `wb_wb_en` && `wb_rd` == rs → `wb_result`
  - else `rf_rdata`.
- `exe_pc_r` = `dec_pc_r`; `exe_rd_r` = `instr[11:7]`; `exe_wb_en_r` = valid && rd ≠ 0.
- Load conditions:
  - Valid decode of a supported instruction loads the fields above with `exe_valid_r` = 1.
  - `dec_valid_r` = 0 loads a bubble.
  - Valid decode of an unsupported instruction loads a bubble with `exe_illegal_r` = 1.
- Bubble: every output is 0 (opc = ADD), except `exe_illegal_r` as stated above.
- Update priority per edge:
  1. `rst`: all outputs 0.
  2. `flush`: bubble, with `exe_illegal_r` = 0.
  3. `stall`: all registers hold; `exe_illegal_r` holds too.
  4. Otherwise: load from decode.

## Timing
- Latency: 1 cycle. Decode inputs sampled at edge N appear on `exe_*` after edge N.
- Forwarding inputs are sampled in the same cycle as decode. Values captured before a stall are held; they are not re-sampled during the stall.
- Reset: all outputs 0 after the first edge with `rst` = 1, regardless of `stall`/`flush`. Reset mid-stall discards held contents.
- `flush` and `stall` together: flush wins; bubble loaded.
- Upstream holds `dec_*` while `stall` = 1. This block does not generate stalls; the load-use hazard is detected elsewhere.
- `exe_illegal_r` is high for exactly one cycle per offending instruction unless held by stall.

## Test plan
- Reset: drive `rst` = 1 with `dec_valid_r` = 1, instr `0x002081B3` → after the edge all outputs are 0.
- ADD x3,x1,x2 (`0x002081B3`), `rf_rdata1` = 5, `rf_rdata2` = 7, no forwarding → next cycle opc = 0000, reg1 = 5, src2 = 7, rd = 3, wb_en = 1, valid = 1.
  - Repeat with SUB (`0x402081B3`) → opc = 1000.
- Forwarding: same ADD with `mem_wb_en` = 1, `mem_rd` = 1, `mem_result` = `0xAAAA0000`, and `wb_wb_en` = 1, `wb_rd` = 1, `wb_result` = 9 → reg1 = `0xAAAA0000` (MEM wins).
  - Then `mem_rd` = 0, `wb_rd` = 0 with rs1 = x0 → reg1 = 0.
- Immediates:
  - SRAI x5,x6,3 (`0x40335293`) → opc = 1101, src2 = `0x00000403`.
  - AUIPC x1,`0x12345` (`0x12345097`), PC = `0x100` → sel_pc = 1, src2 = `0x12345000`, pc = `0x100`.
- Illegal: instr `0x022081B3` (funct7 = `0000001`) → valid = 0, wb_en = 0, illegal = 1 for one cycle.
  - Instr `0x00000000` → same response.
- Stall/flush: load ADD, then stall = 1 for 3 cycles while changing `dec_*` → outputs unchanged.
  - Assert stall = 1 and flush = 1 together → bubble next cycle.
